// File: rtl/main_memory_pkg.sv
// Shared types and constants for the block-transfer main memory: FSM states,
// default geometry/latency and the optional preload image.
package main_memory_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_ADDR_W      = 10;
  localparam int DEF_BLOCK_WORDS = 4;
  localparam int DEF_LATENCY     = 4;

  // Preload image: words 0-7 and words 104-107; everything else is zero.
  localparam int PRELOAD_HI_BASE = 104;

  localparam logic [31:0] PRELOAD_LO [8] = '{
    32'hffabffba, 32'hffccffcc, 32'hffcdffdc, 32'hffadffda,
    32'h00ffaabb, 32'hff00ccdd, 32'h00cc2299, 32'hff00bbaa
  };

  localparam logic [31:0] PRELOAD_HI [4] = '{
    32'habcdabcd, 32'hbcdebcde, 32'hcdefcdef, 32'h12345678
  };

endpackage

// File: rtl/main_memory_array.sv
// Word-organised storage with a one-edge whole-block write port and a
// combinational whole-block read port. Preload selected by MAIN_MEMORY_BURST_INIT_EN.
module main_memory_array
  import main_memory_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int BLK_W       = 6
) (
  input  logic                          clk,
  input  logic                          we,
  input  logic [BLK_W-1:0]              wr_blk,
  input  logic [DATA_W*BLOCK_WORDS-1:0] wr_data,
  input  logic [BLK_W-1:0]              rd_blk,
  output logic [DATA_W*BLOCK_WORDS-1:0] rd_data
);

  localparam int WORD_SEL_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W      = BLK_W + WORD_SEL_W;
  localparam int DEPTH      = BLOCK_WORDS << BLK_W;

`ifdef MAIN_MEMORY_BURST_INIT_EN
  logic [DATA_W-1:0] mem [DEPTH] = '{
    0: DATA_W'(PRELOAD_LO[0]), 1: DATA_W'(PRELOAD_LO[1]),
    2: DATA_W'(PRELOAD_LO[2]), 3: DATA_W'(PRELOAD_LO[3]),
    4: DATA_W'(PRELOAD_LO[4]), 5: DATA_W'(PRELOAD_LO[5]),
    6: DATA_W'(PRELOAD_LO[6]), 7: DATA_W'(PRELOAD_LO[7]),
    PRELOAD_HI_BASE + 0: DATA_W'(PRELOAD_HI[0]),
    PRELOAD_HI_BASE + 1: DATA_W'(PRELOAD_HI[1]),
    PRELOAD_HI_BASE + 2: DATA_W'(PRELOAD_HI[2]),
    PRELOAD_HI_BASE + 3: DATA_W'(PRELOAD_HI[3]),
    default: '0
  };
`else
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
`endif

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < BLOCK_WORDS; k++) begin
        mem[IDX_W'(wr_blk) * IDX_W'(BLOCK_WORDS) + IDX_W'(k)] <= wr_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Word k of block b lives at b*BLOCK_WORDS + k; a block never wraps.
  for (genvar gi = 0; gi < BLOCK_WORDS; gi++) begin : g_rd
    logic [IDX_W-1:0] rd_idx;
    assign rd_idx = IDX_W'(rd_blk) * IDX_W'(BLOCK_WORDS) + IDX_W'(gi);
    assign rd_data[gi*DATA_W +: DATA_W] = mem[rd_idx];
  end

endmodule

// File: rtl/main_memory_burst.sv
// Block-transfer main memory: fixed-latency req/done handshake in front of
// main_memory_array. Optional preload via MAIN_MEMORY_BURST_INIT_EN.
module main_memory_burst
  import main_memory_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int LATENCY     = DEF_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req,
  input  logic                          write,
  input  logic [ADDR_W-1:0]             addr,
  input  logic [DATA_W*BLOCK_WORDS-1:0] W_data,
  output logic                          busy,
  output logic                          done,
  output logic [DATA_W*BLOCK_WORDS-1:0] R_data
);

  localparam int OFF_W = $clog2(BLOCK_WORDS) + 2;
  localparam int BLK_W = ADDR_W - OFF_W;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int BLK_BITS = DATA_W * BLOCK_WORDS;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [BLK_W-1:0]    blk_reg;
  logic                write_reg;
  logic [BLK_BITS-1:0] wdata_reg;
  logic [BLK_BITS-1:0] rdata_reg;
  logic [BLK_BITS-1:0] rd_block;
  logic                finish;
  logic                accept;
  logic                mem_we;

  logic unused_addr_bits;
  assign unused_addr_bits = ^addr[OFF_W-1:0];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    finish     = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          state_next = WAIT;
          cnt_next   = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_reg == '0) begin
          finish     = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Request fields are captured only on acceptance; later req pulses are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_reg   <= '0;
      write_reg <= 1'b0;
      wdata_reg <= '0;
    end else if (accept) begin
      blk_reg   <= addr[ADDR_W-1:OFF_W];
      write_reg <= write;
      wdata_reg <= W_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg <= '0;
    end else if (finish && !write_reg) begin
      rdata_reg <= rd_block;
    end
  end

  // A reset on the commit edge must suppress the write as well.
  assign mem_we = finish && write_reg && !rst;

  main_memory_array #(
    .DATA_W      (DATA_W),
    .BLOCK_WORDS (BLOCK_WORDS),
    .BLK_W       (BLK_W)
  ) u_array (
    .clk     (clk),
    .we      (mem_we),
    .wr_blk  (blk_reg),
    .wr_data (wdata_reg),
    .rd_blk  (blk_reg),
    .rd_data (rd_block)
  );

  assign done   = (state_reg == DONE);
  assign busy   = (state_reg != IDLE);
  assign R_data = rdata_reg;

endmodule
